rf_writeback_sequencer: RTL and testbench

//  Write-side driver for register_file's single write port (PW/C/RFLd). Accepts writeback

---
 rtl/rf_writeback_sequencer_if.sv | 32 +++
 rtl/rf_writeback_sequencer.sv | 160 ++++++++++++++++
 tb/tb_rf_writeback_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_sequencer_if.sv
// Bundle of the request handshake, flush and register_file write-port signals.
// The WB stage drives the master side; the sequencer is the slave.
// COUNT width follows the sequencer pointer width AW (AW+1 bits).
interface rf_writeback_sequencer_if #(
  parameter int AW = 2
);
  logic          FLUSH;
  logic          IN_VALID;
  logic          IN_READY;
  logic          IN_LD0;
  logic [3:0]    IN_RD0;
  logic [31:0]   IN_D0;
  logic          IN_LD1;
  logic [3:0]    IN_RD1;
  logic [31:0]   IN_D1;
  logic [31:0]   PW;
  logic [3:0]    C;
  logic          RFLd;
  logic          PC_WR;
  logic          BUSY;
  logic [AW:0]   COUNT;

  modport master (
    output FLUSH, IN_VALID, IN_LD0, IN_RD0, IN_D0, IN_LD1, IN_RD1, IN_D1,
    input  IN_READY, PW, C, RFLd, PC_WR, BUSY, COUNT
  );

  modport slave (
    input  FLUSH, IN_VALID, IN_LD0, IN_RD0, IN_D0, IN_LD1, IN_RD1, IN_D1,
    output IN_READY, PW, C, RFLd, PC_WR, BUSY, COUNT
  );
endinterface

// File: rtl/rf_writeback_sequencer.sv
// Serialises two-write writeback requests onto register_file's single write port.
// Latency: request accepted at edge N into an empty FIFO appears on PW/C/RFLd after edge N+1.
// Backpressure: IN_READY drops when DEPTH requests are queued; no bypass when full.
module rf_writeback_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  rf_writeback_sequencer_if.slave   bus
);

  typedef struct packed {
    logic        ld0;
    logic [3:0]  rd0;
    logic [31:0] d0;
    logic        ld1;
    logic [3:0]  rd1;
    logic [31:0] d1;
  } req_t;

  // S_SEC: head's secondary already written, its primary still owed (head not popped).
  // S_PRI: the previous write finished a request (head popped).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEC  = 2'd1,
    S_PRI  = 2'd2
  } state_t;

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pw;
  logic [3:0]    r_c;
  logic          r_rfld;

  req_t          w_in_req;
  req_t          w_head;
  logic          w_in_ready;
  logic          w_nonempty;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [31:0]   w_pw_nxt;
  logic [3:0]    w_c_nxt;

  assign w_in_req = '{ld0: bus.IN_LD0, rd0: bus.IN_RD0, d0: bus.IN_D0,
                      ld1: bus.IN_LD1, rd1: bus.IN_RD1, d1: bus.IN_D1};
  assign w_head     = r_mem[r_rd_ptr];
  assign w_in_ready = (r_count < (AW+1)'(DEPTH));
  assign w_nonempty = (r_count != '0);
  // Null requests complete the handshake but never occupy an entry.
  assign w_push     = bus.IN_VALID && w_in_ready && !bus.FLUSH && (bus.IN_LD0 || bus.IN_LD1);

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: a head with both writes passes through S_SEC; anything else finishes in one cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.FLUSH) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_SEC:   w_state_nxt = S_PRI;
        default: begin
          if (!w_nonempty)                 w_state_nxt = S_IDLE;
          else if (w_head.ld1 && w_head.ld0) w_state_nxt = S_SEC;
          else                             w_state_nxt = S_PRI;
        end
      endcase
    end
  end

  // Write selection: secondary before primary so a shared Rd ends with the primary value.
  always_comb begin
    w_issue  = 1'b0;
    w_pop    = 1'b0;
    w_pw_nxt = r_pw;
    w_c_nxt  = r_c;
    if (!bus.FLUSH) begin
      case (r_state)
        S_SEC: begin
          w_issue  = 1'b1;
          w_pop    = 1'b1;
          w_pw_nxt = w_head.d0;
          w_c_nxt  = w_head.rd0;
        end
        default: begin
          if (w_nonempty) begin
            w_issue = 1'b1;
            if (w_head.ld1) begin
              w_pw_nxt = w_head.d1;
              w_c_nxt  = w_head.rd1;
              w_pop    = !w_head.ld0;
            end else begin
              w_pw_nxt = w_head.d0;
              w_c_nxt  = w_head.rd0;
              w_pop    = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; flush empties the queue ahead of any push/pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Request storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_req;
  end

  // Registered write port; PW/C hold their last value when nothing is issued.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rfld <= 1'b0;
      r_pw   <= '0;
      r_c    <= '0;
    end else begin
      r_rfld <= w_issue;
      r_pw   <= w_pw_nxt;
      r_c    <= w_c_nxt;
    end
  end

  assign bus.IN_READY = w_in_ready;
  assign bus.PW       = r_pw;
  assign bus.C        = r_c;
  assign bus.RFLd     = r_rfld;
  assign bus.PC_WR    = r_rfld && (r_c == 4'hF);
  assign bus.BUSY     = w_nonempty || r_rfld;
  assign bus.COUNT    = r_count;

endmodule

// File: tb/tb_rf_writeback_sequencer.sv
// Randomised and directed stimulus for rf_writeback_sequencer against a write-queue model.
// Model: each accepted request appends its writes (secondary, then primary) to a queue;
// the port retires one queued write per cycle, requests accepted at an edge start next edge.
module tb_rf_writeback_sequencer;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] d;
    logic        last;
  } wr_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  rf_writeback_sequencer_if #(.AW(2)) bus();

  rf_writeback_sequencer #(.DEPTH(4), .AW(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_wr   = 0;
  wr_t         wq[$];
  int          m_cnt  = 0;
  logic        e_rfld = 1'b0;
  logic [3:0]  e_c    = '0;
  logic [31:0] e_pw   = '0;
  logic [31:0] m_rf [16];
  logic [31:0] d_rf [16];
  logic        saw_full = 1'b0;
  logic        last_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check IN_READY, step model at the edge, check outputs.
  task automatic cycle(input logic fl, input logic vld,
                       input logic l0, input logic [3:0] r0, input logic [31:0] d0,
                       input logic l1, input logic [3:0] r1, input logic [31:0] d1);
    logic rdy;
    wr_t  w;
    bus.FLUSH    = fl;
    bus.IN_VALID = vld;
    bus.IN_LD0   = l0;
    bus.IN_RD0   = r0;
    bus.IN_D0    = d0;
    bus.IN_LD1   = l1;
    bus.IN_RD1   = r1;
    bus.IN_D1    = d1;
    rdy = (m_cnt < 4);
    #1;
    chk("in_ready", bus.IN_READY, rdy);
    if (!rdy) saw_full = 1'b1;
    last_acc = vld && rdy && !fl;
    @(posedge CLK);
    if (fl) begin
      wq.delete();
      m_cnt  = 0;
      e_rfld = 1'b0;
    end else begin
      if (wq.size() > 0) begin
        w = wq.pop_front();
        e_rfld = 1'b1;
        e_c    = w.rd;
        e_pw   = w.d;
        m_rf[w.rd] = w.d;
        if (w.last) m_cnt--;
      end else begin
        e_rfld = 1'b0;
      end
      if (vld && rdy && (l0 || l1)) begin
        if (l1) wq.push_back('{rd: r1, d: d1, last: !l0});
        if (l0) wq.push_back('{rd: r0, d: d0, last: 1'b1});
        m_cnt++;
      end
    end
    #1;
    chk("rfld",  bus.RFLd,  e_rfld);
    chk("c",     bus.C,     e_c);
    chk("pw",    bus.PW,    e_pw);
    chk("pc_wr", bus.PC_WR, e_rfld && (e_c == 4'hF));
    chk("count", bus.COUNT, m_cnt);
    chk("busy",  bus.BUSY,  (m_cnt != 0) || e_rfld);
    if (bus.RFLd) begin
      d_rf[bus.C] = bus.PW;
      n_wr++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  // Holds a request until the handshake completes, bounded to 20 cycles.
  task automatic send(input logic l0, input logic [3:0] r0, input logic [31:0] d0,
                      input logic l1, input logic [3:0] r1, input logic [31:0] d1);
    int k;
    k = 0;
    last_acc = 1'b0;
    while (!last_acc && k < 20) begin
      cycle(1'b0, 1'b1, l0, r0, d0, l1, r1, d1);
      k++;
    end
    if (!last_acc) chk("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int wr_start;
    for (int i = 0; i < 16; i++) begin
      m_rf[i] = '0;
      d_rf[i] = '0;
    end
    bus.FLUSH = 1'b0; bus.IN_VALID = 1'b0;
    bus.IN_LD0 = 1'b0; bus.IN_RD0 = '0; bus.IN_D0 = '0;
    bus.IN_LD1 = 1'b0; bus.IN_RD1 = '0; bus.IN_D1 = '0;

    // Reset values while RST is held.
    #2;
    chk("rst_rfld",  bus.RFLd,     1'b0);
    chk("rst_count", bus.COUNT,    0);
    chk("rst_ready", bus.IN_READY, 1'b1);
    chk("rst_busy",  bus.BUSY,     1'b0);
    chk("rst_pw",    bus.PW,       0);
    chk("rst_c",     bus.C,        0);
    chk("rst_pcwr",  bus.PC_WR,    1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Single primary write.
    send(1'b1, 4'd3, 32'h5A, 1'b0, 4'd0, 32'h0);
    idle(3);
    // Dual write: secondary then primary.
    send(1'b1, 4'd2, 32'h7, 1'b1, 4'd13, 32'h100);
    idle(3);
    // Same destination: primary value must be final.
    send(1'b1, 4'd4, 32'h9, 1'b1, 4'd4, 32'h1);
    idle(3);
    chk("same_reg_r4", d_rf[4], 32'h9);

    // Back-to-back duals to fill the FIFO and wrap the pointers, plus a null request.
    saw_full = 1'b0;
    wr_start = n_wr;
    for (int i = 0; i < 6; i++)
      send(1'b1, 4'(i), 32'hA000 + 32'(i), 1'b1, 4'(i + 8), 32'hB000 + 32'(i));
    send(1'b0, 4'd1, 32'hDEAD, 1'b0, 4'd2, 32'hBEEF);
    idle(14);
    chk("full_seen", saw_full, 1'b1);
    chk("wrap_writes", n_wr - wr_start, 12);

    // PC write, then flush with requests queued.
    send(1'b1, 4'hF, 32'h40, 1'b0, 4'd0, 32'h0);
    idle(3);
    send(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66);
    send(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0);
    send(1'b1, 4'd8, 32'h88, 1'b1, 4'd9, 32'h99);
    cycle(1'b1, 1'b1, 1'b1, 4'd10, 32'hAA, 1'b0, 4'd0, 32'h0);
    chk("flush_count", bus.COUNT, 0);
    idle(4);

    // Randomised traffic including flushes and null requests.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 60),
            1'($urandom), 4'($urandom), $urandom,
            1'($urandom), 4'($urandom), $urandom);
    end

    // Asynchronous reset in the middle of traffic.
    send(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    send(1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h44);
    bus.IN_VALID = 1'b0;
    RST = 1'b1;
    #1;
    chk("midrst_rfld",  bus.RFLd,     1'b0);
    chk("midrst_count", bus.COUNT,    0);
    chk("midrst_ready", bus.IN_READY, 1'b1);
    chk("midrst_busy",  bus.BUSY,     1'b0);
    wq.delete();
    m_cnt = 0; e_rfld = 1'b0; e_c = '0; e_pw = '0;
    #2;
    RST = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
            1'($urandom), 4'($urandom), $urandom,
            1'($urandom), 4'($urandom), $urandom);
    end
    idle(12);

    for (int i = 0; i < 16; i++) chk($sformatf("rf_r%0d", i), d_rf[i], m_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
